// File: rtl/addn_pkg.sv
// Shared types and sizing helpers for the sequential slice adder.
package addn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CHUNK = 4;

  // Number of slices (and therefore cycles) needed to cover the operand.
  function automatic int calc_nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Slice counter width; a single-slice build still needs one bit.
  function automatic int calc_cnt_w(input int nchunk);
    if (nchunk <= 1) begin
      return 1;
    end else begin
      return $clog2(nchunk);
    end
  endfunction

endpackage

// File: rtl/addn_add_chunk.sv
// Combinational CHUNK-bit ripple adder used as the single slice datapath.
// c_msb is the carry into the top bit, needed for signed overflow.
module add_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb
);

  // Ripple the carry bit by bit across the slice.
  always_comb begin
    logic [CHUNK:0] cy_v;
    cy_v    = {(CHUNK + 1){1'b0}};
    cy_v[0] = ci;
    s       = {CHUNK{1'b0}};
    for (int i = 0; i < CHUNK; i++) begin
      s[i]      = a[i] ^ b[i] ^ cy_v[i];
      cy_v[i+1] = (a[i] & b[i]) | (cy_v[i] & (a[i] ^ b[i]));
    end
    co    = cy_v[CHUNK];
    c_msb = cy_v[CHUNK-1];
  end

endmodule

// File: rtl/addn_seq.sv
// Multi-cycle WIDTH-bit adder/subtractor: one CHUNK-bit slice per cycle,
// LSB slice first, through a single add_chunk instance.
// Optional build macro ADDN_EARLY_EXIT_EN: finish as soon as the remaining
// upper operand bits are zero and no carry is pending.
module addn_seq
  import addn_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ov
);

  localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
  localparam int CNT_W  = calc_cnt_w(NCHUNK);
  localparam logic [CNT_W-1:0] K_LAST = CNT_W'(NCHUNK - 1);

  state_e             state_r;
  state_e             state_n_s;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   beff_r;
  logic [WIDTH-1:0]   res_r;
  logic [WIDTH-1:0]   res_upd_s;
  logic [WIDTH-1:0]   s_r;
  logic               carry_r;
  logic               co_r;
  logic               ov_r;
  logic               out_valid_r;
  logic [CNT_W-1:0]   k_r;
  logic [CHUNK-1:0]   slice_a_s;
  logic [CHUNK-1:0]   slice_b_s;
  logic [CHUNK-1:0]   slice_s_s;
  logic               slice_co_s;
  logic               slice_cmsb_s;
  logic               in_ready_s;
  logic               accept_s;
  logic               last_s;
  logic               early_s;
  logic               finish_s;

  assign in_ready_s = (state_r == IDLE);
  assign accept_s   = in_valid & in_ready_s;
  assign last_s     = (k_r == K_LAST);

  assign slice_a_s  = a_r[int'(k_r) * CHUNK +: CHUNK];
  assign slice_b_s  = beff_r[int'(k_r) * CHUNK +: CHUNK];

  add_chunk #(.CHUNK(CHUNK)) u_add_chunk (
    .a     (slice_a_s),
    .b     (slice_b_s),
    .ci    (carry_r),
    .s     (slice_s_s),
    .co    (slice_co_s),
    .c_msb (slice_cmsb_s)
  );

`ifdef ADDN_EARLY_EXIT_EN
  logic hi_zero_s;
  assign hi_zero_s = (((a_r | beff_r) >> ((int'(k_r) + 1) * CHUNK)) == {WIDTH{1'b0}});
  assign early_s   = ~last_s & ~slice_co_s & hi_zero_s;
`else
  assign early_s   = 1'b0;
`endif

  assign finish_s = last_s | early_s;

  // Result register with the current slice merged in place (no shifting).
  always_comb begin
    res_upd_s = res_r;
    res_upd_s[int'(k_r) * CHUNK +: CHUNK] = slice_s_s;
  end

  // Next-state logic for the IDLE/RUN/DONE handshake sequence.
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_n_s = RUN;
        end else begin
          state_n_s = IDLE;
        end
      end
      RUN: begin
        if (finish_s) begin
          state_n_s = DONE;
        end else begin
          state_n_s = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_n_s = IDLE;
        end else begin
          state_n_s = DONE;
        end
      end
      default: begin
        state_n_s = IDLE;
      end
    endcase
  end

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n_s;
    end
  end

  // Operand capture, slice accumulation and registered result/flags.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      a_r         <= {WIDTH{1'b0}};
      beff_r      <= {WIDTH{1'b0}};
      res_r       <= {WIDTH{1'b0}};
      carry_r     <= 1'b0;
      k_r         <= {CNT_W{1'b0}};
      s_r         <= {WIDTH{1'b0}};
      co_r        <= 1'b0;
      ov_r        <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            a_r     <= a;
            beff_r  <= sub ? ~b : b;
            carry_r <= sub ? 1'b1 : ci;
            res_r   <= {WIDTH{1'b0}};
            k_r     <= {CNT_W{1'b0}};
          end
        end
        RUN: begin
          res_r   <= res_upd_s;
          carry_r <= slice_co_s;
          k_r     <= k_r + CNT_W'(1'b1);
          if (finish_s) begin
            s_r         <= res_upd_s;
            out_valid_r <= 1'b1;
            if (early_s) begin
              co_r <= 1'b0;
              ov_r <= 1'b0;
            end else begin
              co_r <= slice_co_s;
              ov_r <= slice_cmsb_s ^ slice_co_s;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign s         = s_r;
  assign co        = co_r;
  assign ov        = ov_r;

endmodule

// File: tb/tb_addn_seq.sv
// Directed bench for addn_seq (WIDTH=32, CHUNK=4) with a result scoreboard.
module tb_addn_seq;

  localparam int WIDTH  = 32;
  localparam int CHUNK  = 4;
  localparam int NCHUNK = WIDTH / CHUNK;

  typedef struct {
    logic [31:0] s;
    logic        co;
    logic        ov;
    int          lat;
  } exp_t;

  logic              clk;
  logic              clrn;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic              ci;
  logic              sub;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  s;
  logic              co;
  logic              ov;

  exp_t sb[$];
  int   n_checks;
  int   n_errors;

  addn_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .clrn      (clrn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .co        (co),
    .ov        (ov)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: full-width arithmetic plus expected latency.
  function automatic exp_t model(input logic [31:0] ta, input logic [31:0] tb_v,
                                 input logic tci, input logic tsub);
    exp_t        e;
    logic [31:0] bb;
    logic        cin;
    logic [32:0] full;
    bb   = tsub ? ~tb_v : tb_v;
    cin  = tsub ? 1'b1 : tci;
    full = {1'b0, ta} + {1'b0, bb} + {32'd0, cin};
    e.s  = full[31:0];
    e.co = full[32];
    e.ov = (ta[31] == bb[31]) && (full[31] != ta[31]);
    e.lat = NCHUNK;
`ifdef ADDN_EARLY_EXIT_EN
    for (int k = 0; k < NCHUNK - 1; k++) begin
      int          w;
      logic [63:0] mask;
      logic [63:0] low;
      w    = (k + 1) * CHUNK;
      mask = (64'd1 << w) - 64'd1;
      low  = ({32'd0, ta} & mask) + ({32'd0, bb} & mask) + {63'd0, cin};
      if (low[w] == 1'b0 && (ta >> w) == 32'd0 && (bb >> w) == 32'd0) begin
        e.lat = k + 1;
        break;
      end
    end
`endif
    return e;
  endfunction

  task automatic start_op(input logic [31:0] ta, input logic [31:0] tb_v,
                          input logic tci, input logic tsub, input bit track);
    check("in_ready_idle", {63'd0, in_ready}, 64'd1);
    a        = ta;
    b        = tb_v;
    ci       = tci;
    sub      = tsub;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (track) begin
      sb.push_back(model(ta, tb_v, tci, tsub));
    end
  endtask

  task automatic wait_result(input string tag);
    int   cyc;
    exp_t e;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, "_sb_nonempty"}, {63'd0, (sb.size() != 0)}, 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_latency"}, 64'(cyc), 64'(e.lat));
      check({tag, "_s"}, {32'd0, s}, {32'd0, e.s});
      check({tag, "_co"}, {63'd0, co}, {63'd0, e.co});
      check({tag, "_ov"}, {63'd0, ov}, {63'd0, e.ov});
    end
  endtask

  task automatic take_result(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_out_valid_drop"}, {63'd0, out_valid}, 64'd0);
    check({tag, "_in_ready_after"}, {63'd0, in_ready}, 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                        input logic tci, input logic tsub);
    start_op(ta, tb_v, tci, tsub, 1'b1);
    wait_result(tag);
    take_result(tag);
  endtask

  initial begin
    logic [31:0] hs;
    logic        hco;
    logic        hov;
    n_checks  = 0;
    n_errors  = 0;
    clrn      = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = 32'd0;
    b         = 32'd0;
    ci        = 1'b0;
    sub       = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_s", {32'd0, s}, 64'd0);
    check("rst_co", {63'd0, co}, 64'd0);
    check("rst_ov", {63'd0, ov}, 64'd0);
    clrn = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);

    run_op("add_wrap", 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
    run_op("sub_borrow", 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1);
    run_op("add_ci_ovf", 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
    run_op("sub_ci_ign", 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b1);

    // Backpressure: result held while in_valid is driven.
    start_op(32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b1, 1'b0, 1'b1);
    wait_result("bp");
    hs  = s;
    hco = co;
    hov = ov;
    a        = 32'h0000_1111;
    b        = 32'h0000_2222;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_out_valid", {63'd0, out_valid}, 64'd1);
      check("bp_in_ready", {63'd0, in_ready}, 64'd0);
      check("bp_s_hold", {32'd0, s}, {32'd0, hs});
      check("bp_co_hold", {63'd0, co}, {63'd0, hco});
      check("bp_ov_hold", {63'd0, ov}, {63'd0, hov});
    end
    in_valid = 1'b0;
    take_result("bp");
    check("bp_s_after_take", {32'd0, s}, {32'd0, hs});

    // Reset in the middle of RUN (slice 3 pending).
    start_op(32'hDEAD_BEEF, 32'h0123_4567, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    clrn = 1'b0;
    #1;
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_s", {32'd0, s}, 64'd0);
    check("midrst_co", {63'd0, co}, 64'd0);
    check("midrst_ov", {63'd0, ov}, 64'd0);
    @(negedge clk);
    clrn = 1'b1;
    @(posedge clk);
    #1;
    run_op("post_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);

    run_op("small_add", 32'h0000_0003, 32'h0000_0005, 1'b0, 1'b0);
    run_op("small_carry", 32'h0000_000F, 32'h0000_0001, 1'b0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      run_op("rand", $urandom, $urandom, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/addn_seq.md
Name: addn_seq

Overview:
- Multi-cycle, parametrised N-bit adder/subtractor.
- Processes operands one CHUNK-bit slice per cycle, LSB slice first, through a single ripple slice adder.
- Trades latency for area in the datapath, where a full-width combinational adder is too large.
- Valid/ready handshake on input and result sides; reports sum, carry-out and signed overflow.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of CHUNK and at least CHUNK.
- CHUNK, 4, bits added per cycle (slice width); must be at least 1.
- NCHUNK (localparam), WIDTH/CHUNK, number of slices/cycles.

Ports:
- clk  in  1  clock, rising edge
- clrn  in  1  asynchronous active-low reset
- in_valid  in  1  operands present
- in_ready  out  1  block can accept operands
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- ci  in  1  carry-in (add mode only)
- sub  in  1  1: a - b; 0: a + b + ci
- out_valid  out  1  result valid
- out_ready  in  1  consumer takes result
- s  out  WIDTH  sum/difference
- co  out  1  carry-out (sub: 1 = no borrow)
- ov  out  1  signed overflow

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset (clrn=0) at any time, including mid-RUN:
  - state -> IDLE, current operation discarded.
  - s=0, co=0, ov=0, out_valid=0.
  - in_ready=1 from the first clk edge after clrn deasserts; in_ready is combinational from state==IDLE.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at edge E0:
    - latch a.
    - latch beff = sub ? ~b : b.
    - carry register = sub ? 1 : ci.
    - clear result register; chunk counter k=0.
    - go to RUN.
- RUN:
  - in_ready=0.
  - Each edge: slice k = a[k*CHUNK+:CHUNK] + beff[k*CHUNK+:CHUNK] + carry.
  - Slice sum is written into result[k*CHUNK+:CHUNK]; result does not shift.
  - Carry register <= slice carry-out; k increments.
  - At the edge processing k=NCHUNK-1:
    - s <= final result.
    - co <= slice carry-out.
    - ov <= carry into MSB XOR carry out of MSB; the slice provides carry into its top bit.
    - go to DONE.
- Latency: out_valid rises exactly NCHUNK cycles after the accept edge. With WIDTH=32, CHUNK=4 this is 8 cycles.
- DONE:
  - out_valid=1; s/co/ov held stable.
  - in_ready=0; in_valid is ignored.
  - On out_ready=1 at an edge: out_valid -> 0, go to IDLE. s/co/ov keep their last values until the next completion.
  - A new input is accepted no earlier than the cycle after the result is taken (no same-cycle turnaround).
- out_ready while not in DONE is ignored.
- CHUNK=WIDTH degenerates to 1-cycle latency; the same FSM applies.
- Counter width: $clog2(NCHUNK), minimum 1 bit.

Optional Feature:
- Macro: ADDN_EARLY_EXIT_EN.
- Defined:
  - In RUN, after processing slice k (k<NCHUNK-1), finish early if all three hold: slice carry-out=0; a bits above slice k are all zero; beff bits above slice k are all zero.
  - On early finish: go to DONE at that edge, with s=result (upper bits already zero), co=0, ov=0.
  - Latency becomes k+1 cycles.
  - Subtraction rarely qualifies, because ~b has ones in its upper bits.
- Undefined: latency is always NCHUNK cycles.

Decomposition:
- Package addn_pkg holds:
  - state enum (IDLE, RUN, DONE);
  - default WIDTH/CHUNK constants;
  - a function computing NCHUNK and the counter width.
- One sub-module, add_chunk: combinational CHUNK-bit ripple adder.
  - Inputs: a, b, ci.
  - Outputs: s, co, c_msb (carry into top bit).
  - Instantiated once in addn_seq.
- addn_seq contains the FSM, counter, operand/result registers and flags.

Test Plan (WIDTH=32, CHUNK=4):
- Add 0x00000001 + 0xFFFFFFFF, ci=0, sub=0 -> s=0x00000000, co=1, ov=0; out_valid exactly 8 cycles after accept.
- Sub 0x80000000 - 0x00000001 -> s=0x7FFFFFFF, co=1, ov=1. Sub 0x00000000 - 0x00000001 -> s=0xFFFFFFFF, co=0, ov=0.
- Add 0x7FFFFFFF + 0x00000000, ci=1 -> s=0x80000000, co=0, ov=1. Confirms ci is ignored when sub=1 by repeating as a subtraction with ci=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 -> out_valid stays 1, s/co/ov unchanged, in_ready=0. Raise out_ready -> one transfer, then in_ready=1 the next cycle.
- Pull clrn low during RUN at k=3 -> out_valid=0, s=co=ov=0 immediately. After release, 0x12345678 + 0x11111111 -> s=0x23456789 in 8 cycles.
- 0x00000003 + 0x00000005: with ADDN_EARLY_EXIT_EN -> s=0x00000008, out_valid 1 cycle after accept; without the macro -> 8 cycles. Same s/co/ov both builds.
